// File: rtl/skin_segmenter_if.sv
// Pixel-in / object-out bus for the skin segmenter.
// Valid-only streams: pix_valid is consumed on every rising edge it is high (no ready);
// obj_valid marks the single cycle an output sample is present.
interface skin_segmenter_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [7:0]  pix_y;
    logic [7:0]  pix_cb;
    logic [7:0]  pix_cr;
    logic        obj_valid;
    logic        object_image;
    logic [8:0]  obj_col;
    logic [8:0]  obj_row;
    logic        flag;
    logic [16:0] skin_count;
    logic [1:0]  state_dbg;

    modport master (
        output pix_valid, pix_sof, pix_y, pix_cb, pix_cr,
        input  obj_valid, object_image, obj_col, obj_row, flag, skin_count, state_dbg
    );

    modport slave (
        input  pix_valid, pix_sof, pix_y, pix_cb, pix_cr,
        output obj_valid, object_image, obj_col, obj_row, flag, skin_count, state_dbg
    );
endinterface

// File: rtl/skin_segmenter.sv
// YCbCr skin classifier with a causal 3-tap horizontal majority filter and per-frame
// skin pixel count; outputs appear two cycles after each accepted pixel.
module skin_segmenter #(
    parameter int          IMAGE_WIDTH  = 384,
    parameter int          IMAGE_HEIGHT = 216,
    parameter logic [7:0]  CB_MIN       = 8'd77,
    parameter logic [7:0]  CB_MAX       = 8'd127,
    parameter logic [7:0]  CR_MIN       = 8'd133,
    parameter logic [7:0]  CR_MAX       = 8'd173,
    parameter logic [7:0]  Y_MIN        = 8'd40
) (
    input  logic             clk,
    input  logic             rst,
    skin_segmenter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [8:0]  LAST_COL = 9'(IMAGE_WIDTH - 1);
    localparam logic [8:0]  LAST_ROW = 9'(IMAGE_HEIGHT - 1);
    localparam logic [16:0] CNT_MAX  = 17'h1FFFF;

    // Frame tracking: col_q/row_q hold the position the next non-sof pixel will take.
    state_t     state_q;
    logic [8:0] col_q, row_q;
    logic       h1_q, h2_q;

    // Stage 1: filtered bit plus its tags, one cycle after acceptance.
    logic       s1_valid_q, s1_bit_q, s1_sof_q, s1_last_q;
    logic [8:0] s1_col_q, s1_row_q;

    // Stage 2: registered outputs and frame statistics.
    logic        obj_valid_q, obj_img_q, flag_q;
    logic [8:0]  obj_col_q, obj_row_q;
    logic [16:0] run_cnt_q, skin_count_q;

    logic        accept;
    logic [8:0]  pcol, prow;
    logic        raw, hist1, hist2, filt;
    logic        at_eol, is_last;
    logic [8:0]  col_d, row_d;
    state_t      state_d;
    logic [16:0] cnt_base, cnt_d;

    always_comb begin
        accept  = bus.pix_valid && (bus.pix_sof || state_q == ACTIVE);
        pcol    = bus.pix_sof ? 9'd0 : col_q;
        prow    = bus.pix_sof ? 9'd0 : row_q;
        raw     = (bus.pix_y >= Y_MIN) &&
                  (bus.pix_cb >= CB_MIN) && (bus.pix_cb <= CB_MAX) &&
                  (bus.pix_cr >= CR_MIN) && (bus.pix_cr <= CR_MAX);
        // Column 0 sees an all-zero history so nothing leaks across a row boundary.
        hist1   = (pcol != 9'd0) && h1_q;
        hist2   = (pcol != 9'd0) && h2_q;
        filt    = (raw & hist1) | (raw & hist2) | (hist1 & hist2);
        at_eol  = (pcol == LAST_COL);
        is_last = at_eol && (prow == LAST_ROW);
        col_d   = at_eol ? 9'd0 : pcol + 9'd1;
        row_d   = at_eol ? prow + 9'd1 : prow;
        state_d = is_last ? DONE : ACTIVE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= 9'd0;
            row_q   <= 9'd0;
            h1_q    <= 1'b0;
            h2_q    <= 1'b0;
        end else if (accept) begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            h1_q    <= raw;
            h2_q    <= hist1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_bit_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_col_q   <= 9'd0;
            s1_row_q   <= 9'd0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_bit_q  <= filt;
                s1_sof_q  <= bus.pix_sof;
                s1_last_q <= is_last;
                s1_col_q  <= pcol;
                s1_row_q  <= prow;
            end
        end
    end

    // Counting restarts when the sof pixel itself emits, so older in-flight pixels
    // land in the abandoned total and never in the new frame.
    always_comb begin
        cnt_base = s1_sof_q ? 17'd0 : run_cnt_q;
        cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + {16'd0, s1_bit_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            obj_valid_q  <= 1'b0;
            obj_img_q    <= 1'b0;
            obj_col_q    <= 9'd0;
            obj_row_q    <= 9'd0;
            flag_q       <= 1'b0;
            run_cnt_q    <= 17'd0;
            skin_count_q <= 17'd0;
        end else begin
            obj_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                obj_img_q <= s1_bit_q;
                obj_col_q <= s1_col_q;
                obj_row_q <= s1_row_q;
                if (s1_last_q) begin
                    skin_count_q <= cnt_d;
                    run_cnt_q    <= 17'd0;
                    flag_q       <= 1'b1;
                end else begin
                    run_cnt_q <= cnt_d;
                    if (s1_sof_q) begin
                        flag_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.obj_valid    = obj_valid_q;
    assign bus.object_image = obj_img_q;
    assign bus.obj_col      = obj_col_q;
    assign bus.obj_row      = obj_row_q;
    assign bus.flag         = flag_q;
    assign bus.skin_count   = skin_count_q;
    assign bus.state_dbg    = state_q;
endmodule
